// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction-fetch controller
package ifu_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - fetch PC register, next value chosen redirect > increment > hold
module ifu_pc_reg
  import ifu_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en_i,
  input  logic [INST_W-1:0] redirect_pc_i,
  input  logic              inc_en_i,
  output logic [INST_W-1:0] pc_o
);

  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_en_i) begin
      pc_d = word_align(redirect_pc_i);
    end else if (inc_en_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - single-outstanding instruction fetch sequencer with decode hold buffer
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [INST_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_pc,
  output logic [31:0]       fetch_cnt
);

  ifu_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [INST_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic              pc_inc;
  logic [INST_W-1:0] pc_q;

  // A redirect retargets the PC in every state; the FSM only decides what happens to in-flight data.
  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .redirect_en_i (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .inc_en_i      (pc_inc),
    .pc_o          (pc_q)
  );

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    pc_inc       = 1'b0;

    case (state_q)
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
          pc_inc       = 1'b1;
          fetch_cnt_d  = fetch_cnt_q + 32'd1;
          state_d      = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      fetch_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  // rst is folded in so no request escapes while reset is still held.
  assign imem_req_valid = (state_q == S_REQ) & ~redirect_valid & ~rst;
  assign imem_addr      = word_align(pc_q);
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule
